// File: rtl/mastermind_pkg.sv
// Shared widths, state encoding and helpers for the code-guessing game.
package mastermind_pkg;
    localparam int LETTER_W = 3;
    localparam int NUM_POS  = 4;
    localparam int CODE_W   = 12;

    typedef enum logic [2:0] {
        IDLE,
        SET_SECRET,
        PLAY,
        CHECK,
        DONE
    } state_t;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction
endpackage

// File: rtl/letter_entry_buffer.sv
// Shift buffer collecting NUM_POS letters, newest at the bottom, with a fill counter.
module letter_entry_buffer
    import mastermind_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                shift,
    input  logic                clear,
    input  logic [LETTER_W-1:0] letter,
    output logic [CODE_W-1:0]   code,
    output logic [1:0]          idx,
    output logic                full_next
);
    // The counter wraps to 0 on the completing shift, so no explicit reload is needed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            code <= '0;
            idx  <= '0;
        end else if (clear) begin
            code <= '0;
            idx  <= '0;
        end else if (shift) begin
            code <= {code[CODE_W-LETTER_W-1:0], letter};
            idx  <= idx + 2'd1;
        end
    end

    assign full_next = shift && (idx == 2'(NUM_POS - 1));
endmodule

// File: rtl/game_sequencer.sv
// Game FSM: secret entry, guessing, one-cycle check and win/loss bookkeeping.
module game_sequencer
    import mastermind_pkg::*;
#(
    parameter int MAX_ATTEMPTS = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [LETTER_W-1:0] letter_in,
    input  logic                enter,
    output logic [CODE_W-1:0]   secret_val,
    output logic [CODE_W-1:0]   guess_val,
    output logic                game_over,
    output logic                win,
    output logic [3:0]          attempts,
    output logic [1:0]          entry_idx,
    output logic                secret_hide
);
    state_t              state, state_nxt;
    logic                shift, clear, full_next;
    logic [CODE_W-1:0]   code;
    logic [CODE_W-1:0]   code_done;
    logic                match, last_try;

    letter_entry_buffer u_buf (
        .clk       (clk),
        .reset     (reset),
        .shift     (shift),
        .clear     (clear),
        .letter    (letter_in),
        .code      (code),
        .idx       (entry_idx),
        .full_next (full_next)
    );

    // Word as it will look once the letter being entered this cycle is shifted in.
    assign code_done = CODE_W'({code, letter_in});
    assign match     = (guess_val == secret_val);
    assign last_try  = ((attempts + 4'd1) == 4'(MAX_ATTEMPTS));

    always_comb begin
        state_nxt = state;
        shift     = 1'b0;
        clear     = 1'b0;
        if (start) begin
            state_nxt = SET_SECRET;
            clear     = 1'b1;
        end else begin
            case (state)
                SET_SECRET: begin
                    shift = enter;
                    if (full_next) state_nxt = PLAY;
                end
                PLAY: begin
                    shift = enter;
                    if (full_next) state_nxt = CHECK;
                end
                CHECK:   state_nxt = (match || last_try) ? DONE : PLAY;
                default: state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            secret_val <= '0;
            guess_val  <= '0;
            attempts   <= '0;
            win        <= 1'b0;
            game_over  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (start) begin
                guess_val <= '0;
                attempts  <= '0;
                win       <= 1'b0;
                game_over <= 1'b0;
            end else begin
                if (state == SET_SECRET && full_next) secret_val <= code_done;
                if (state == PLAY && full_next)       guess_val  <= code_done;
                if (state == CHECK) begin
                    attempts <= sat_inc(attempts);
                    win      <= match;
                    if (state_nxt == DONE) game_over <= 1'b1;
                end
            end
        end
    end

    assign secret_hide = (state == SET_SECRET);
endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer with a two-attempt limit.
module tb_game_sequencer;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  letter_in = '0;
    logic        enter = 1'b0;
    logic [11:0] secret_val, guess_val;
    logic        game_over, win, secret_hide;
    logic [3:0]  attempts;
    logic [1:0]  entry_idx;
    int          n_cmp = 0;
    int          n_bad = 0;

    game_sequencer #(.MAX_ATTEMPTS(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .letter_in   (letter_in),
        .enter       (enter),
        .secret_val  (secret_val),
        .guess_val   (guess_val),
        .game_over   (game_over),
        .win         (win),
        .attempts    (attempts),
        .entry_idx   (entry_idx),
        .secret_hide (secret_hide)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are read at the next falling edge.
    task automatic press(input logic [2:0] l);
        letter_in = l;
        enter     = 1'b1;
        @(negedge clk);
        enter     = 1'b0;
    endtask

    task automatic press4(input logic [2:0] a, b, c, d);
        press(a); press(b); press(c); press(d);
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".secret"}, secret_val, 12'o0);
        chk({tag, ".guess"},  guess_val,  12'o0);
        chk({tag, ".attempts"}, 12'(attempts), 12'd0);
        chk({tag, ".idx"},    12'(entry_idx), 12'd0);
        chk({tag, ".over"},   12'(game_over), 12'd0);
        chk({tag, ".win"},    12'(win), 12'd0);
        chk({tag, ".hide"},   12'(secret_hide), 12'd0);
    endtask

    initial begin
        #3;
        chk_all_zero("reset");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        press(3'd5);
        chk("idle_enter.idx", 12'(entry_idx), 12'd0);
        chk("idle_enter.hide", 12'(secret_hide), 12'd0);

        // Secret then immediate win.
        do_start();
        chk("win.hide", 12'(secret_hide), 12'd1);
        press(3'd3); press(3'd5);
        chk("win.idx2", 12'(entry_idx), 12'd2);
        press(3'd1); press(3'd7);
        chk("win.secret", secret_val, 12'o3517);
        chk("win.idx0", 12'(entry_idx), 12'd0);
        chk("win.hide_off", 12'(secret_hide), 12'd0);
        press4(3'd3, 3'd5, 3'd1, 3'd7);
        chk("win.guess", guess_val, 12'o3517);
        chk("win.check_over", 12'(game_over), 12'd0);
        chk("win.check_att", 12'(attempts), 12'd0);
        @(negedge clk);
        chk("win.win", 12'(win), 12'd1);
        chk("win.over", 12'(game_over), 12'd1);
        chk("win.att", 12'(attempts), 12'd1);

        // Enter ignored in DONE.
        for (int i = 0; i < 5; i++) press(3'(i + 2));
        chk("done.guess", guess_val, 12'o3517);
        chk("done.att", 12'(attempts), 12'd1);
        chk("done.idx", 12'(entry_idx), 12'd0);
        chk("done.over", 12'(game_over), 12'd1);

        // Miss returns to PLAY; enter during CHECK is dropped.
        do_start();
        chk("miss.clr_guess", guess_val, 12'o0);
        chk("miss.clr_win", 12'(win), 12'd0);
        chk("miss.clr_over", 12'(game_over), 12'd0);
        press4(3'd0, 3'd1, 3'd2, 3'd3);
        chk("miss.secret", secret_val, 12'o0123);
        press4(3'd0, 3'd1, 3'd2, 3'd4);
        chk("miss.guess", guess_val, 12'o0124);
        press(3'd6);
        chk("miss.att", 12'(attempts), 12'd1);
        chk("miss.over", 12'(game_over), 12'd0);
        chk("miss.drop_idx", 12'(entry_idx), 12'd0);
        press(3'd6);
        chk("miss.idx1", 12'(entry_idx), 12'd1);

        // Loss at the two-attempt limit.
        do_start();
        press4(3'd0, 3'd1, 3'd2, 3'd3);
        press4(3'd7, 3'd7, 3'd7, 3'd7);
        @(negedge clk);
        chk("loss.att1", 12'(attempts), 12'd1);
        chk("loss.over1", 12'(game_over), 12'd0);
        press4(3'd6, 3'd6, 3'd6, 3'd6);
        @(negedge clk);
        chk("loss.att2", 12'(attempts), 12'd2);
        chk("loss.over2", 12'(game_over), 12'd1);
        chk("loss.win", 12'(win), 12'd0);
        chk("loss.guess", guess_val, 12'o6666);

        // Start beats enter mid-guess.
        do_start();
        press4(3'd0, 3'd1, 3'd2, 3'd3);
        press4(3'd4, 3'd4, 3'd4, 3'd4);
        @(negedge clk);
        press(3'd2); press(3'd2);
        chk("prio.idx2", 12'(entry_idx), 12'd2);
        start = 1'b1;
        press(3'd5);
        start = 1'b0;
        chk("prio.hide", 12'(secret_hide), 12'd1);
        chk("prio.idx", 12'(entry_idx), 12'd0);
        chk("prio.att", 12'(attempts), 12'd0);
        chk("prio.guess", guess_val, 12'o0);
        press4(3'd1, 3'd2, 3'd3, 3'd4);
        chk("prio.secret", secret_val, 12'o1234);

        // Asynchronous reset mid-entry.
        press(3'd6); press(3'd6);
        #2 reset = 1'b0;
        #1;
        chk_all_zero("arst");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        press(3'd3);
        chk("arst.ignored_idx", 12'(entry_idx), 12'd0);
        chk("arst.idle_hide", 12'(secret_hide), 12'd0);
        do_start();
        press(3'd3);
        chk("arst.restart_idx", 12'(entry_idx), 12'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/game_sequencer.md
GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 SHALL have parameter MAX_ATTEMPTS, default 8, meaning the number of guesses allowed before a loss (range 1-15).
REQ-002 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  single-cycle pulse (debounced upstream); begins or restarts a game.
REQ-005 SHALL have port letter_in  input  3  letter value 0-7; every value is valid.
REQ-006 SHALL have port enter  input  1  single-cycle pulse; commits letter_in.
REQ-007 SHALL have port secret_val  output  12  committed secret code; first-entered letter in [11:9], last in [2:0].
REQ-008 SHALL have port guess_val  output  12  last complete guess, packed like secret_val; drives the LED comparison path.
REQ-009 SHALL have port game_over  output  1  high in DONE only.
REQ-010 SHALL have port win  output  1  high in DONE when the final guess equalled secret_val.
REQ-011 SHALL have port attempts  output  4  count of completed guesses in the current game.
REQ-012 SHALL have port entry_idx  output  2  number of letters already held in the entry buffer (0-3).
REQ-013 SHALL have port secret_hide  output  1  high in SET_SECRET, so the display blanks secret entry.

Function
REQ-014 SHALL implement states IDLE, SET_SECRET, PLAY, CHECK, DONE.
REQ-015 SHALL on start in any state, with priority over enter, go to SET_SECRET next cycle, clear entry buffer, entry_idx, attempts, guess_val, win.
REQ-016 SHALL in SET_SECRET and PLAY, on enter, shift letter_in into the 12-bit entry buffer at [2:0] (older letters move up 3 bits) and increment entry_idx.
REQ-017 SHALL ignore enter in IDLE, CHECK and DONE.
REQ-018 SHALL on the 4th enter in SET_SECRET load secret_val from the completed buffer, set entry_idx to 0, and go to PLAY the next cycle.
REQ-019 SHALL on the 4th enter in PLAY load guess_val from the completed buffer, set entry_idx to 0, and go to CHECK; guess_val changes only at this point or on clear.
REQ-020 SHALL spend exactly one cycle in CHECK.
REQ-021 SHALL in CHECK increment attempts, saturating at 15.
REQ-022 SHALL in CHECK, if guess_val == secret_val, set win=1 and go to DONE.
REQ-023 SHALL in CHECK, if there is no match and attempts+1 == MAX_ATTEMPTS, set win=0 and go to DONE.
REQ-024 SHALL in CHECK, in all other cases, return to PLAY.
REQ-025 SHALL make game_over registered: it rises in the cycle after CHECK exits to DONE and stays high until start or reset.
REQ-026 SHALL keep secret_val, guess_val and attempts stable in DONE.
REQ-027 SHALL, when enter arrives in the cycle that CHECK is exited, drop that enter (no buffering).

Reset
REQ-028 SHALL on reset low, immediately (asynchronously) force state IDLE, secret_val=0, guess_val=0, attempts=0, entry_idx=0, entry buffer=0, game_over=0, win=0, secret_hide=0.
REQ-029 SHALL, when reset is asserted mid-entry or mid-CHECK, discard the partial buffer; after release, stay in IDLE until start.

Structure
REQ-030 SHALL take LETTER_W=3, NUM_POS=4, CODE_W=12 and the state enumeration from shared package mastermind_pkg.
REQ-031 SHALL implement the shift buffer and entry_idx counter as sub-module letter_entry_buffer (inputs: shift, clear, letter; outputs: code, idx, full_next).
REQ-032 SHALL keep the FSM and attempts counter in game_sequencer; no other sub-modules.

Verification
REQ-033 SHALL cover secret-then-win: start; enter 3,5,1,7; enter 3,5,1,7 -> secret_val=12'o3517, guess_val=12'o3517, win=1, game_over=1, attempts=1.
REQ-034 SHALL cover a loss at the limit: MAX_ATTEMPTS=2, secret 0,1,2,3; guesses 7,7,7,7 and 6,6,6,6 -> attempts=2, game_over=1, win=0, guess_val=12'o6666.
REQ-035 SHALL cover a miss returning to PLAY: secret 0,1,2,3; guess 0,1,2,4 -> CHECK one cycle, attempts=1, game_over=0; the next enter gives entry_idx=1.
REQ-036 SHALL cover start and enter in the same cycle during PLAY with entry_idx=2 -> state SET_SECRET, entry_idx=0, attempts=0, letter not captured.
REQ-037 SHALL cover reset mid-entry: reset low after 2 letters in PLAY -> all outputs 0 before the next clock edge; enter after release is ignored until start.
REQ-038 SHALL cover enter ignored in DONE: pulse enter 5 times -> guess_val, attempts and entry_idx unchanged.
